// File: rtl/chipmunk_pkg.sv
// Shared types and opcode constants for the chipmunk accumulator CPU.
package chipmunk_pkg;

  typedef enum logic [1:0] {
    StFetch   = 2'd0,
    StDecode  = 2'd1,
    StExecute = 2'd2,
    StHalt    = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    AluPass,
    AluAnd,
    AluAdd,
    AluOra,
    AluEor,
    AluInc
  } alu_op_e;

  localparam logic [7:0] OP_LDA_IMM = 8'h00;
  localparam logic [7:0] OP_LDX_IMM = 8'h01;
  localparam logic [7:0] OP_LDY_IMM = 8'h02;
  localparam logic [7:0] OP_AND_IMM = 8'h20;
  localparam logic [7:0] OP_ADD_IMM = 8'h21;
  localparam logic [7:0] OP_ORA_IMM = 8'h22;
  localparam logic [7:0] OP_EOR_IMM = 8'h23;
  localparam logic [7:0] OP_NOP     = 8'h80;
  localparam logic [7:0] OP_INX     = 8'h81;
  localparam logic [7:0] OP_INY     = 8'h82;
  localparam logic [7:0] OP_HLT     = 8'h83;
  localparam logic [7:0] OP_TAX     = 8'h98;
  localparam logic [7:0] OP_TAY     = 8'h99;
  localparam logic [7:0] OP_TXA     = 8'h9A;
  localparam logic [7:0] OP_TYA     = 8'h9B;

  // Upper-nibble classes; the lower nibble supplies address bits [11:8].
  localparam logic [3:0] CLS_LDA_ABS = 4'h4;
  localparam logic [3:0] CLS_STA_ABS = 4'h5;
  localparam logic [3:0] CLS_JMP     = 4'h6;
  localparam logic [3:0] CLS_BEQ     = 4'h7;

endpackage

// File: rtl/chipmunk_alu.sv
// Combinational 8-bit ALU: pass-through, logic ops, add and increment, with zero detect.
module chipmunk_alu
  import chipmunk_pkg::*;
(
  input  alu_op_e     op_i,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [7:0]  result_o,
  output logic        zero_o
);

  always_comb begin
    result_o = b_i;
    unique case (op_i)
      AluPass: result_o = b_i;
      AluAnd:  result_o = a_i & b_i;
      AluAdd:  result_o = a_i + b_i;
      AluOra:  result_o = a_i | b_i;
      AluEor:  result_o = a_i ^ b_i;
      AluInc:  result_o = a_i + 8'd1;
      default: result_o = b_i;
    endcase
    zero_o = (result_o == 8'h00);
  end

endmodule

// File: rtl/chipmunk_cpu.sv
// 8-bit accumulator CPU core with 12-bit addressing over an asynchronous external memory.
module chipmunk_cpu
  import chipmunk_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] startPC,
  input  logic [7:0]  dataBus,
  output logic [7:0]  dataBusWrite,
  output logic [11:0] addrBus,
  output logic        weMem,
  output logic        done
);

  state_e      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [7:0]  a_q, a_d, x_q, x_d, y_q, y_d;
  logic [7:0]  ir_q, ir_d, data_q, data_d;
  logic        z_q, z_d;
  logic        done_q, done_d;

  alu_op_e     alu_op;
  logic [7:0]  alu_a, alu_b, alu_res;
  logic        alu_zero;
  logic [11:0] pc_inc, target;

  assign pc_inc = pc_q + 12'd1;
  assign target = {ir_q[3:0], dataBus};

  chipmunk_alu u_alu (
    .op_i     (alu_op),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_res),
    .zero_o   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= startPC;
      a_q     <= 8'h00;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      ir_q    <= 8'h00;
      data_q  <= 8'h00;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ir_q    <= ir_d;
      data_q  <= data_d;
      z_q     <= z_d;
      done_q  <= done_d;
    end
  end

  // Operand selection; the default passes dataBus through, which also serves LDA abs.
  always_comb begin
    alu_op = AluPass;
    alu_a  = a_q;
    alu_b  = dataBus;
    case (ir_q)
      OP_AND_IMM: alu_op = AluAnd;
      OP_ADD_IMM: alu_op = AluAdd;
      OP_ORA_IMM: alu_op = AluOra;
      OP_EOR_IMM: alu_op = AluEor;
      OP_INX: begin
        alu_op = AluInc;
        alu_a  = x_q;
      end
      OP_INY: begin
        alu_op = AluInc;
        alu_a  = y_q;
      end
      OP_TAX, OP_TAY: alu_b = a_q;
      OP_TXA:         alu_b = x_q;
      OP_TYA:         alu_b = y_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    x_d     = x_q;
    y_d     = y_q;
    ir_d    = ir_q;
    data_d  = data_q;
    z_d     = z_q;
    unique case (state_q)
      StFetch: begin
        ir_d    = dataBus;
        pc_d    = pc_inc;
        state_d = StDecode;
      end
      StDecode: begin
        state_d = StFetch;
        case (ir_q)
          OP_LDA_IMM, OP_AND_IMM, OP_ADD_IMM, OP_ORA_IMM, OP_EOR_IMM: begin
            a_d  = alu_res;
            z_d  = alu_zero;
            pc_d = pc_inc;
          end
          OP_LDX_IMM: begin
            x_d  = alu_res;
            z_d  = alu_zero;
            pc_d = pc_inc;
          end
          OP_LDY_IMM: begin
            y_d  = alu_res;
            z_d  = alu_zero;
            pc_d = pc_inc;
          end
          OP_INX, OP_TAX: begin
            x_d = alu_res;
            z_d = alu_zero;
          end
          OP_INY, OP_TAY: begin
            y_d = alu_res;
            z_d = alu_zero;
          end
          OP_TXA, OP_TYA: begin
            a_d = alu_res;
            z_d = alu_zero;
          end
          OP_HLT: state_d = StHalt;
          default: begin
            case (ir_q[7:4])
              CLS_JMP: pc_d = target;
              CLS_BEQ: pc_d = z_q ? target : pc_inc;
              CLS_LDA_ABS, CLS_STA_ABS: begin
                data_d  = dataBus;
                pc_d    = pc_inc;
                state_d = StExecute;
              end
              default: ;
            endcase
          end
        endcase
      end
      StExecute: begin
        state_d = StFetch;
        if (ir_q[7:4] == CLS_LDA_ABS) begin
          a_d = alu_res;
          z_d = alu_zero;
        end
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase
  end

  assign done_d = (state_d == StHalt);

  always_comb begin
    addrBus      = pc_q;
    weMem        = 1'b0;
    dataBusWrite = a_q;
    done         = done_q;
    if (state_q == StExecute) begin
      addrBus = {ir_q[3:0], data_q};
      weMem   = (ir_q[7:4] == CLS_STA_ABS);
    end
  end

endmodule

// File: tb/tb_chipmunk_cpu.sv
// Scoreboard bench: an instruction-level model predicts stores and the halt point.
module tb_chipmunk_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] startPC = 12'h000;
  logic [7:0]  dataBus;
  logic [7:0]  dataBusWrite;
  logic [11:0] addrBus;
  logic        weMem;
  logic        done;

  logic [7:0]  mem   [4096];
  logic [7:0]  mem_m [4096];

  typedef struct {
    bit          is_halt;
    logic [11:0] addr;
    logic [7:0]  data;
    int          cyc;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          halt_seen = 0;
  logic [11:0] gp;

  chipmunk_cpu dut (
    .clk          (clk),
    .reset        (reset),
    .startPC      (startPC),
    .dataBus      (dataBus),
    .dataBusWrite (dataBusWrite),
    .addrBus      (addrBus),
    .weMem        (weMem),
    .done         (done)
  );

  always #5 clk = ~clk;

  assign dataBus = mem[addrBus];
  always @(posedge clk) if (weMem) mem[addrBus] <= dataBusWrite;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  // Monitor: every store strobe and the first cycle of done must match the next expectation.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (!reset && (weMem || (done && !halt_seen))) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got we=%b done=%b addr=%h data=%h cyc=%0d, required none",
                 weMem, done, addrBus, dataBusWrite, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.is_halt != done || e.is_halt == weMem || e.addr != addrBus ||
            e.data != dataBusWrite || e.cyc != cyc) begin
          errors++;
          $display("FAIL %s: got done=%b we=%b addr=%h data=%h cyc=%0d, required done=%b addr=%h data=%h cyc=%0d",
                   e.is_halt ? "halt" : "store", done, weMem, addrBus, dataBusWrite, cyc,
                   e.is_halt, e.addr, e.data, e.cyc);
        end
      end
      if (done) halt_seen = 1;
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 8'h83;
  endtask

  task automatic emit(input logic [7:0] b);
    mem[gp] = b;
    gp = gp + 12'd1;
  endtask

  // Instruction-level reference: cycle cost 2 per instruction, 3 for absolute loads/stores.
  task automatic model_run(input logic [11:0] spc, output int total);
    logic [11:0] pc, tgt;
    logic [7:0]  a, x, y, op, opr;
    bit          z, halted;
    int          t, steps;
    a = 0; x = 0; y = 0; z = 0; pc = spc; t = 0; halted = 0; steps = 0;
    while (!halted && steps < 2000) begin
      op  = mem_m[pc];
      pc  = pc + 12'd1;
      opr = mem_m[pc];
      tgt = {op[3:0], opr};
      steps++;
      case (op)
        8'h00: begin a = opr; z = (a == 0); pc = pc + 12'd1; t += 2; end
        8'h01: begin x = opr; z = (x == 0); pc = pc + 12'd1; t += 2; end
        8'h02: begin y = opr; z = (y == 0); pc = pc + 12'd1; t += 2; end
        8'h20: begin a = a & opr; z = (a == 0); pc = pc + 12'd1; t += 2; end
        8'h21: begin a = a + opr; z = (a == 0); pc = pc + 12'd1; t += 2; end
        8'h22: begin a = a | opr; z = (a == 0); pc = pc + 12'd1; t += 2; end
        8'h23: begin a = a ^ opr; z = (a == 0); pc = pc + 12'd1; t += 2; end
        8'h81: begin x = x + 8'd1; z = (x == 0); t += 2; end
        8'h82: begin y = y + 8'd1; z = (y == 0); t += 2; end
        8'h83: begin
          exp_q.push_back('{is_halt: 1'b1, addr: pc, data: a, cyc: t + 2});
          t += 2;
          halted = 1;
        end
        8'h98: begin x = a; z = (x == 0); t += 2; end
        8'h99: begin y = a; z = (y == 0); t += 2; end
        8'h9A: begin a = x; z = (a == 0); t += 2; end
        8'h9B: begin a = y; z = (a == 0); t += 2; end
        default: begin
          if (op[7:4] == 4'h6) begin
            pc = tgt; t += 2;
          end else if (op[7:4] == 4'h7) begin
            pc = z ? tgt : pc + 12'd1; t += 2;
          end else if (op[7:4] == 4'h4) begin
            a = mem_m[tgt]; z = (a == 0); pc = pc + 12'd1; t += 3;
          end else if (op[7:4] == 4'h5) begin
            exp_q.push_back('{is_halt: 1'b0, addr: tgt, data: a, cyc: t + 2});
            mem_m[tgt] = a; pc = pc + 12'd1; t += 3;
          end else begin
            t += 2;
          end
        end
      endcase
    end
    total = t;
  endtask

  task automatic start_prog(input logic [11:0] spc, output int budget);
    @(negedge clk);
    reset   = 1'b1;
    startPC = spc;
    @(negedge clk);
    for (int i = 0; i < 4096; i++) mem_m[i] = mem[i];
    exp_q.delete();
    halt_seen = 0;
    model_run(spc, budget);
    reset = 1'b0;
  endtask

  task automatic run_prog(input logic [11:0] spc);
    int budget, n;
    start_prog(spc, budget);
    n = 0;
    while (!halt_seen && n < budget + 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!halt_seen) begin
      errors++;
      $display("FAIL halt_timeout: got no done after %0d cycles, required done by cycle %0d",
               n, budget);
    end
    chk("leftover_events", 16'(exp_q.size()), 16'd0);
  endtask

  task automatic gen_random();
    int          r, n;
    logic [11:0] tgt;
    logic [7:0]  undef [6];
    undef = '{8'h03, 8'h24, 8'h3C, 8'h84, 8'h9C, 8'hFF};
    clear_mem();
    gp = 12'($urandom_range(0, 12'h300));
    n  = $urandom_range(8, 20);
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(0, 15);
      case (r)
        0, 1, 2: begin emit(8'(r)); emit(8'($urandom_range(0, 255))); end
        3, 4, 5, 6: begin
          emit(8'h20 + 8'(r - 3));
          emit(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
        end
        7: emit(8'h81 + 8'($urandom_range(0, 1)));
        8: emit(8'h98 + 8'($urandom_range(0, 3)));
        9: emit(($urandom_range(0, 1) == 0) ? 8'h80 : undef[$urandom_range(0, 5)]);
        10: begin emit(8'h40 | 8'($urandom_range(0, 15))); emit(8'($urandom_range(0, 255))); end
        13, 14: begin
          // Branch targets land on even addresses in the upper half holding STA-then-HLT tails.
          tgt = 12'h800 + 12'(2 * $urandom_range(0, 12'h3FE));
          if (r == 14 && $urandom_range(0, 3) != 0) begin
            emit(8'h80);
          end else begin
            emit(((r == 13) ? 8'h70 : 8'h60) | 8'(tgt[11:8]));
            emit(tgt[7:0]);
            mem[tgt]         = 8'h57;
            mem[tgt + 12'd1] = 8'($urandom_range(0, 255));
          end
        end
        default: begin emit(8'h54 + 8'($urandom_range(0, 3))); emit(8'($urandom_range(0, 255))); end
      endcase
    end
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL global_timeout: got simulation still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          budget, n;
    logic [11:0] spc;
    logic [7:0]  p1 [6];

    // Basic arithmetic and transfer, no stores.
    clear_mem();
    p1 = '{8'h00, 8'h08, 8'h21, 8'h05, 8'h98, 8'h83};
    for (int i = 0; i < 6; i++) mem[i] = p1[i];
    run_prog(12'h000);

    // Single absolute store, then reset while halted.
    clear_mem();
    mem[0] = 8'h00; mem[1] = 8'h05; mem[2] = 8'h5A; mem[3] = 8'h34; mem[4] = 8'h83;
    run_prog(12'h000);
    chk("halt_done", 16'(done), 16'd1);
    chk("halt_we", 16'(weMem), 16'd0);
    startPC = 12'h100;
    reset   = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_halt_done", 16'(done), 16'd0);
    chk("rst_halt_we", 16'(weMem), 16'd0);
    chk("rst_halt_addr", 16'(addrBus), 16'h100);
    chk("rst_halt_a", 16'(dataBusWrite), 16'h00);

    // BEQ taken (0xFF+1 wraps to zero) and not taken.
    clear_mem();
    p1 = '{8'h00, 8'hFF, 8'h21, 8'h01, 8'h7F, 8'h10};
    for (int i = 0; i < 6; i++) mem[i] = p1[i];
    run_prog(12'h000);
    mem[3] = 8'h02;
    run_prog(12'h000);

    // PC wrap from 0xFFF, INX result visible via TXA/STA, Z clear so BEQ falls through.
    clear_mem();
    mem[12'hFFF] = 8'h81;
    mem[0] = 8'h9A; mem[1] = 8'h54; mem[2] = 8'h00; mem[3] = 8'h7F; mem[4] = 8'h00;
    run_prog(12'hFFF);

    // Reset during the store's execute cycle.
    clear_mem();
    p1 = '{8'h01, 8'h11, 8'h02, 8'h22, 8'h00, 8'hAA};
    for (int i = 0; i < 6; i++) mem[12'h100 + 12'(i)] = p1[i];
    mem[12'h106] = 8'h54; mem[12'h107] = 8'h10;
    start_prog(12'h100, budget);
    n = 0;
    while (weMem !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("mid_exec_we_seen", 16'(weMem), 16'd1);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("rst_exec_done", 16'(done), 16'd0);
    chk("rst_exec_we", 16'(weMem), 16'd0);
    chk("rst_exec_addr", 16'(addrBus), 16'h100);
    chk("rst_exec_a", 16'(dataBusWrite), 16'h00);
    p1 = '{8'h9A, 8'h54, 8'h00, 8'h9B, 8'h54, 8'h01};
    for (int i = 0; i < 6; i++) mem[12'h100 + 12'(i)] = p1[i];
    mem[12'h106] = 8'h83;
    run_prog(12'h100);

    // Randomized programs.
    for (int t = 0; t < 40; t++) begin
      gen_random();
      spc = 12'h000;
      for (int i = 0; i < 12'h400; i++) begin
        if (mem[i] != 8'h83) begin
          spc = 12'(i);
          break;
        end
      end
      run_prog(spc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chipmunk_cpu.md
Name: chipmunk_cpu

Overview:
Minimal 8-bit accumulator CPU with a 12-bit address space, registers A, X and Y, and a zero flag. It fetches from an external asynchronous (combinational) memory over a shared address bus. It writes through a separate write-data bus with a write enable, and raises `done` after executing HLT. It is the top-level core; program memory is external to it.

Parameters:
None. Data width is fixed at 8 bits and address width at 12 bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- startPC  in  12  PC value loaded at reset.
- dataBus  in  8  read data; valid combinationally for the current addrBus.
- dataBusWrite  out  8  write data; always equals aReg.
- addrBus  out  12  memory address, combinational from state.
- weMem  out  1  memory write strobe; combinational, high only in EXECUTE of STA.
- done  out  1  registered; high while in HALT state.

Behaviour:
- Internal registers: pcReg[11:0], aReg, xReg, yReg, irReg, dataReg (all 8 bits), zFlag, state[1:0].
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, HALT=3.
- Reset (sync, overrides everything, including mid-instruction and HALT):
  - pcReg<=startPC; aReg, xReg, yReg, irReg, dataReg<=0; zFlag<=0.
  - state<=FETCH; done<=0. weMem is 0 in FETCH.
- addrBus:
  - FETCH and DECODE: pcReg.
  - EXECUTE: {irReg[3:0], dataReg}.
  - HALT: pcReg.
- FETCH: irReg<=dataBus; pcReg<=pcReg+1; go to DECODE.
- DECODE, 1-byte ops (no operand read, PC unchanged, next state FETCH unless noted):
  - 0x80 NOP; 0x81 INX; 0x82 INY.
  - 0x83 HLT: go to HALT.
  - 0x98 TAX; 0x99 TAY; 0x9A TXA; 0x9B TYA.
  - Any undefined opcode executes as NOP.
- DECODE, 2-byte immediate ops (operand = dataBus at pcReg; pcReg<=pcReg+1; complete this cycle; next state FETCH):
  - 0x00 LDA #; 0x01 LDX #; 0x02 LDY #.
  - 0x20 AND #; 0x21 ADD # (A<=A+n mod 256, no carry kept); 0x22 ORA #; 0x23 EOR #.
- DECODE, 2-byte absolute/control ops (target = {op[3:0], operand}, operand read as above):
  - 0x6h JMP: pcReg<=target; next FETCH.
  - 0x7h BEQ: pcReg<=target if zFlag=1, else pcReg+1; next FETCH.
  - 0x4h LDA abs, 0x5h STA abs: dataReg<=operand; pcReg<=pcReg+1; go to EXECUTE.
- EXECUTE (always returns to FETCH):
  - LDA abs: aReg<=dataBus.
  - STA abs: weMem=1 for this cycle only.
- HALT: done=1; no register changes; state held until reset.
- Flags: zFlag<=(result==0) on every load, ALU, INX/INY and transfer op; unchanged by STA, JMP, BEQ, NOP, HLT.
- Wrap-around: pcReg wraps 0xFFF->0x000; INX/INY wrap 0xFF->0x00 and set Z.
- Latency: 1-byte op = 2 cycles; immediate/JMP/BEQ = 2 cycles; LDA/STA abs = 3 cycles.

Decomposition:
- Package chipmunk_pkg: state enum (FETCH/DECODE/EXECUTE/HALT) and opcode constants (OP_LDA_IMM=0x00 … OP_HLT=0x83, class nibbles 0x4/0x5/0x6/0x7).
- One combinational sub-module, chipmunk_alu: inputs op select, a, b; outputs 8-bit result and zero. Covers AND/ADD/ORA/EOR/pass/increment.

Test Plan:
- Memory 00 08 21 05 98 83, rest 83; startPC=0; reset 1 cycle then release:
  - A=0x08 after cycle 2, A=0x0D after cycle 4, X=0x0D after cycle 6.
  - HALT entered after cycle 8; done=1; PC=0x006; weMem never asserted.
- Program 00 05 5A 34 83: weMem=1 for exactly one cycle with addrBus=0xA34 and dataBusWrite=0x05; done then set.
- Program 00 FF 21 01 7F 10 at 0x000, with 83 at 0xF10: A=0x00, Z=1; branch taken; HLT fetched at addrBus 0xF10.
- Same program with 21 02 instead: A=0x01, Z=0; branch not taken; next fetch at 0x006.
- startPC=0xFFF holding 81, 0x000 holding 83: after INX, X=1 and Z=0; PC wraps to 0x000; HLT executes.
- Assert reset while in HALT and mid-EXECUTE with startPC=0x100: next cycle has state=0, done=0, weMem=0, addrBus=0x100, and A, X, Y = 0.
